and_persist_filter: RTL and testbench

Downstream consumer of the registered `and_gate` output. Requires `y` to stay high for `HOLD_CYCLES` consecutive samples before it asserts a debounced `match`, and low for `REL_CYCLES` consecutive samples before it releases it. Each qualified match produces one-cycle edge pulses, a saturating event count, and an event record delivered over a valid/ready port. Runs in the same clock domain as `and_gate`, so the input needs no synchronizer.

---
 rtl/and_pkg.sv | 30 +++
 rtl/and_sat_counter.sv | 48 ++++
 rtl/and_persist_filter.sv | 178 +++++++++++++++++
 tb/tb_and_persist_filter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/and_pkg.sv
// ---------------------------------------------------------------------------
// and_pkg
// Shared definitions for the and_gate consumer blocks:
//   - persist_state_t : 2-bit state of the persistence filter FSM
//   - max_u()         : helper used to size the internal run/release counters
//   - params_ok()     : elaboration-time legality check of the filter timing
// ---------------------------------------------------------------------------
package and_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    ACTIVE  = 2'd2,
    DISARM  = 2'd3
  } persist_state_t;

  localparam int unsigned MIN_HOLD_CYCLES = 2;
  localparam int unsigned MIN_REL_CYCLES  = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // A single-cycle hold would need the match to assert from IDLE directly,
  // which the ARM stage cannot express; zero release cycles is meaningless.
  function automatic bit params_ok(input int unsigned hold, input int unsigned rel);
    return (hold >= MIN_HOLD_CYCLES) && (rel >= MIN_REL_CYCLES);
  endfunction

endpackage

// File: rtl/and_sat_counter.sv
// ---------------------------------------------------------------------------
// and_sat_counter
// CNT_W-bit saturating up-counter with synchronous clear.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   inc_i      : count one event
//   clr_i      : clear; an event in the same cycle leaves the count at 1
//   cnt_o      : registered count
//   cnt_next_o : value cnt_o takes at the next edge (lets the parent capture
//                the post-update count on the same edge)
// ---------------------------------------------------------------------------
module and_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_next_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_next_o = cnt_q;
    if (clr_i) begin
      cnt_next_o = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_next_o = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next_o;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/and_persist_filter.sv
// ---------------------------------------------------------------------------
// and_persist_filter
// Debounces the registered and_gate output: match asserts after HOLD_CYCLES
// consecutive high samples and releases after REL_CYCLES consecutive lows.
// Each qualified rise bumps a saturating event count and offers an event
// record on a valid/ready port.
//   clk        : rising-edge clock
//   reset      : synchronous active-low reset (priority over all inputs)
//   y_in       : registered and_gate output (same clock domain)
//   clr_cnt    : clear event_cnt and ev_ovf
//   match      : debounced level
//   rise_pulse : one cycle, match just went 0->1
//   fall_pulse : one cycle, match just went 1->0
//   event_cnt  : saturating count of rises
//   ev_valid   : event record pending
//   ev_ready   : consumer takes the record when ev_valid & ev_ready
//   ev_data    : event_cnt value as of the rise that made the record
//   ev_ovf     : sticky, a record was dropped while one was pending
// ---------------------------------------------------------------------------
module and_persist_filter
  import and_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned REL_CYCLES  = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             clr_cnt,
  output logic             match,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_cnt,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] ev_data,
  output logic             ev_ovf
);

  if (!params_ok(HOLD_CYCLES, REL_CYCLES)) begin : g_bad_params
    $error("and_persist_filter: HOLD_CYCLES must be >= 2 and REL_CYCLES >= 1");
  end

  localparam int unsigned RUN_W = $clog2(max_u(HOLD_CYCLES, REL_CYCLES) + 1);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0] HOLD_LAST = RUN_W'(HOLD_CYCLES - 1);
  localparam logic [RUN_W-1:0] REL_LAST  = RUN_W'(REL_CYCLES - 1);

  persist_state_t   state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [RUN_W-1:0] rel_cnt_q, rel_cnt_d;
  logic             match_q, match_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ev_valid_q, ev_valid_d;
  logic [CNT_W-1:0] ev_data_q, ev_data_d;
  logic             ev_ovf_q, ev_ovf_d;
  logic [CNT_W-1:0] cnt_next;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      rel_cnt_q  <= '0;
      match_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_data_q  <= '0;
      ev_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      match_q    <= match_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ev_valid_q <= ev_valid_d;
      ev_data_q  <= ev_data_d;
      ev_ovf_q   <= ev_ovf_d;
    end
  end

  // Next-state logic. run_cnt_q holds the number of highs already seen, so
  // the HOLD_CYCLES-th high arrives while run_cnt_q == HOLD_CYCLES-1.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    rel_cnt_d = rel_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (y_in) begin
          state_d   = ARM;
          run_cnt_d = RUN_ONE;
        end
      end
      ARM: begin
        if (!y_in) begin
          state_d = IDLE;
        end else if (run_cnt_q == HOLD_LAST) begin
          state_d = ACTIVE;
        end else begin
          run_cnt_d = run_cnt_q + RUN_ONE;
        end
      end
      ACTIVE: begin
        if (!y_in) begin
          if (REL_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d   = DISARM;
            rel_cnt_d = RUN_ONE;
          end
        end
      end
      DISARM: begin
        if (y_in) begin
          state_d = ACTIVE;
        end else if (rel_cnt_q == REL_LAST) begin
          state_d = IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q + RUN_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic, decoded from the transition so that match and its pulses
  // are registered alongside the state they describe.
  always_comb begin
    match_d = (state_d == ACTIVE) || (state_d == DISARM);
    rise_d  = (state_q == ARM) && (state_d == ACTIVE);
    fall_d  = ((state_q == ACTIVE) || (state_q == DISARM)) && (state_d == IDLE);
  end

  and_sat_counter #(
    .CNT_W (CNT_W)
  ) u_event_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .inc_i      (rise_d),
    .clr_i      (clr_cnt),
    .cnt_o      (event_cnt),
    .cnt_next_o (cnt_next)
  );

  // Event record. A rise replaces the record only if the slot is empty or
  // being drained this cycle; otherwise the new record is lost and flagged.
  // A drop in the same cycle as clr_cnt still sets the flag, since the drop
  // is newer than the clear.
  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_data_d  = ev_data_q;
    ev_ovf_d   = ev_ovf_q;
    if (rise_d && (!ev_valid_q || ev_ready)) begin
      ev_valid_d = 1'b1;
      ev_data_d  = cnt_next;
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
    if (rise_d && ev_valid_q && !ev_ready) begin
      ev_ovf_d = 1'b1;
    end else if (clr_cnt) begin
      ev_ovf_d = 1'b0;
    end
  end

  assign match      = match_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign ev_valid   = ev_valid_q;
  assign ev_data    = ev_data_q;
  assign ev_ovf     = ev_ovf_q;

endmodule

// File: tb/tb_and_persist_filter.sv
// ---------------------------------------------------------------------------
// tb_and_persist_filter
// Drives two filter instances (CNT_W=8 and CNT_W=2, HOLD=4, REL=2) with the
// same stimulus and compares every output every cycle against a model that
// tracks consecutive high/low run lengths and the event record directly.
// ---------------------------------------------------------------------------
module tb_and_persist_filter;

  localparam int HOLD = 4;
  localparam int REL  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       y_in;
  logic       clr_cnt;
  logic       ev_ready;

  logic       match_a, rise_a, fall_a, ev_valid_a, ev_ovf_a;
  logic [7:0] event_cnt_a, ev_data_a;
  logic       match_b, rise_b, fall_b, ev_valid_b, ev_ovf_b;
  logic [1:0] event_cnt_b, ev_data_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  and_persist_filter #(.HOLD_CYCLES(HOLD), .REL_CYCLES(REL), .CNT_W(8)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .clr_cnt    (clr_cnt),
    .match      (match_a),
    .rise_pulse (rise_a),
    .fall_pulse (fall_a),
    .event_cnt  (event_cnt_a),
    .ev_valid   (ev_valid_a),
    .ev_ready   (ev_ready),
    .ev_data    (ev_data_a),
    .ev_ovf     (ev_ovf_a)
  );

  and_persist_filter #(.HOLD_CYCLES(HOLD), .REL_CYCLES(REL), .CNT_W(2)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .clr_cnt    (clr_cnt),
    .match      (match_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b),
    .event_cnt  (event_cnt_b),
    .ev_valid   (ev_valid_b),
    .ev_ready   (ev_ready),
    .ev_data    (ev_data_b),
    .ev_ovf     (ev_ovf_b)
  );

  // Reference model: run lengths of the input decide the level; the record
  // slot is a one-entry buffer that refuses new entries while full.
  typedef struct {
    int hi_run;
    int lo_run;
    bit match;
    bit rise;
    bit fall;
    int cnt;
    bit valid;
    int data;
    bit ovf;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t m;
    m.hi_run = 0; m.lo_run = 0; m.match = 0; m.rise = 0; m.fall = 0;
    m.cnt = 0; m.valid = 0; m.data = 0; m.ovf = 0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input bit y, input bit clr,
                                        input bit rdy, input bit rst, input int cmax);
    bit full_before;
    if (rst) return model_reset();
    m.rise = 0;
    m.fall = 0;
    if (y) begin
      m.hi_run++;
      m.lo_run = 0;
    end else begin
      m.lo_run++;
      m.hi_run = 0;
    end
    if (!m.match && m.hi_run >= HOLD) begin
      m.match = 1;
      m.rise  = 1;
    end else if (m.match && m.lo_run >= REL) begin
      m.match = 0;
      m.fall  = 1;
    end
    if (clr)                          m.cnt = m.rise ? 1 : 0;
    else if (m.rise && m.cnt < cmax)  m.cnt = m.cnt + 1;
    full_before = m.valid;
    if (m.rise && full_before && !rdy) begin
      m.ovf = 1;
    end else begin
      if (clr) m.ovf = 0;
      if (m.rise) begin
        m.valid = 1;
        m.data  = m.cnt;
      end else if (full_before && rdy) begin
        m.valid = 0;
      end
    end
    return m;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    check("a.match",     int'(match_a),     int'(ma.match));
    check("a.rise",      int'(rise_a),      int'(ma.rise));
    check("a.fall",      int'(fall_a),      int'(ma.fall));
    check("a.event_cnt", int'(event_cnt_a), ma.cnt);
    check("a.ev_valid",  int'(ev_valid_a),  int'(ma.valid));
    check("a.ev_data",   int'(ev_data_a),   ma.data);
    check("a.ev_ovf",    int'(ev_ovf_a),    int'(ma.ovf));
    check("b.match",     int'(match_b),     int'(mb.match));
    check("b.rise",      int'(rise_b),      int'(mb.rise));
    check("b.fall",      int'(fall_b),      int'(mb.fall));
    check("b.event_cnt", int'(event_cnt_b), mb.cnt);
    check("b.ev_valid",  int'(ev_valid_b),  int'(mb.valid));
    check("b.ev_data",   int'(ev_data_b),   mb.data);
    check("b.ev_ovf",    int'(ev_ovf_b),    int'(mb.ovf));
  endtask

  // One clock: inputs applied at the falling edge, model advanced at the
  // rising edge, outputs compared at the following falling edge.
  task automatic step(input bit y, input bit clr, input bit rdy, input bit rst);
    y_in     = y;
    clr_cnt  = clr;
    ev_ready = rdy;
    reset    = ~rst;
    @(posedge clk);
    ma = model_step(ma, y, clr, rdy, rst, 255);
    mb = model_step(mb, y, clr, rdy, rst, 3);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input bit y, input bit clr, input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(y, clr, rdy, 1'b0);
  endtask

  initial begin
    ma = model_reset();
    mb = model_reset();
    y_in = 0; clr_cnt = 0; ev_ready = 0; reset = 0;
    @(negedge clk);

    // Reset, with inputs active to show reset wins.
    step(1, 1, 1, 1);
    step(1, 0, 0, 1);
    run(0, 0, 0, 2);

    // Three highs: never qualifies.
    run(1, 0, 0, 3);
    run(0, 0, 0, 3);

    // Six highs with ready low: rise on the 4th, record held.
    run(1, 0, 0, 6);

    // Single-cycle dropout is absorbed, then a real release.
    run(0, 0, 0, 1);
    run(1, 0, 0, 2);
    run(0, 0, 0, 2);
    run(0, 0, 0, 2);

    // Second match while the record is still pending: dropped, ovf set.
    run(1, 0, 0, 5);
    run(0, 0, 0, 3);
    run(0, 1, 0, 1);
    run(0, 0, 0, 2);

    // Five matches with ready high: CNT_W=2 instance saturates at 3.
    for (int k = 0; k < 5; k++) begin
      run(1, 0, 1, 4);
      run(0, 0, 1, 2);
    end

    // Clear coinciding with a rise leaves the count at 1.
    run(1, 0, 1, 3);
    run(1, 1, 1, 1);
    run(0, 0, 1, 3);

    // Reset in ARM after three highs, then a full requalification.
    run(1, 0, 0, 3);
    step(1, 0, 0, 1);
    run(1, 0, 0, 6);
    run(0, 0, 1, 3);

    // Randomized traffic biased toward long high runs.
    for (int i = 0; i < 3000; i++) begin
      bit y, clr, rdy, rst;
      y   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 300) == 0);
      step(y, clr, rdy, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
